// File: rtl/alu_seq_mult_if.sv
// Shared types and the request/response + ALU-port bundle for the sequential multiplier.
package alu_seq_mult_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;
endpackage

interface alu_seq_mult_if;
  import alu_seq_mult_pkg::*;

  logic   req_valid;
  logic   req_ready;
  word_t  req_a;
  word_t  req_b;
  logic   resp_valid;
  logic   resp_ready;
  word_t  resp_product;
  logic   resp_ovf;
  word_t  alu_porta;
  word_t  alu_portb;
  aluop_t alu_op;
  word_t  alu_out;
  logic   alu_nf;
  logic   alu_zf;
  logic   alu_of;

  // master: the client issuing requests and hosting the ALU
  modport master (
    output req_valid, req_a, req_b, resp_ready, alu_out, alu_nf, alu_zf, alu_of,
    input  req_ready, resp_valid, resp_product, resp_ovf, alu_porta, alu_portb, alu_op
  );

  // slave: the multiplier engine
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, alu_out, alu_nf, alu_zf, alu_of,
    output req_ready, resp_valid, resp_product, resp_ovf, alu_porta, alu_portb, alu_op
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Shift-add unsigned multiplier (MULTU engine) that does all accumulation
// through the shared ALU adder; returns low word of the product plus overflow.
module alu_seq_mult
  import alu_seq_mult_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  alu_seq_mult_if.slave bus
);

  localparam int unsigned ITER_W   = 6;
  localparam int unsigned LAST_IT  = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  word_t               acc;
  word_t               mcand;
  word_t               mplier;
  logic [ITER_W-1:0]   iter;
  logic                ovf;
  logic                lost;
  logic                req_ready_q;
  logic                resp_valid_q;

  // ALU status flags carry nothing useful for an add-only requester
  logic unused_alu_flags;
  assign unused_alu_flags = ^{bus.alu_nf, bus.alu_zf, bus.alu_of};

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_product = acc;
  assign bus.resp_ovf     = ovf;
  assign bus.alu_porta    = acc;
  assign bus.alu_portb    = mcand;
  assign bus.alu_op       = ALU_ADD;

  // Control FSM and datapath; handshake outputs are registered alongside state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      iter         <= '0;
      ovf          <= 1'b0;
      lost         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            acc         <= '0;
            mcand       <= bus.req_a;
            mplier      <= bus.req_b;
            iter        <= '0;
            ovf         <= 1'b0;
            lost        <= 1'b0;
            req_ready_q <= 1'b0;
            if (EARLY_TERM && (bus.req_b == '0)) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          // A carry-out, or adding after a 1 has left the top of mcand, means product >= 2^32
          if (mplier[0]) begin
            acc <= bus.alu_out;
            ovf <= ovf | lost | (bus.alu_out < acc);
          end
          lost   <= lost | mcand[WORD_W-1];
          mcand  <= {mcand[WORD_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[WORD_W-1:1]};
          iter   <= iter + ITER_W'(1);
          if ((EARLY_TERM && (mplier[WORD_W-1:1] == '0)) || (iter == ITER_W'(LAST_IT))) begin
            state        <= DONE;
            resp_valid_q <= 1'b1;
          end
        end

        DONE: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_mult.sv
// Directed + randomized bench for alu_seq_mult with a 64-bit arithmetic reference model.
module tb_alu_seq_mult;
  import alu_seq_mult_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passes;

  alu_seq_mult_if bus ();

  alu_seq_mult #(.EARLY_TERM(1'b1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ALU stand-in: plain 32-bit add of the two ports
  assign bus.alu_out = bus.alu_porta + bus.alu_portb;
  assign bus.alu_nf  = bus.alu_out[31];
  assign bus.alu_zf  = (bus.alu_out == 32'd0);
  assign bus.alu_of  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one multiply, measure latency, optionally stall the response for 'hold' cycles
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0]  full;
    logic [31:0]  exp_lo;
    logic         exp_ovf;
    int           n;
    int           k;
    full    = 64'(a) * 64'(b);
    exp_lo  = full[31:0];
    exp_ovf = (full[63:32] != 32'd0);
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;

    check("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = (hold == 0);
    tick();
    bus.req_valid = 1'b0;
    check("ready_low_after_accept", 32'(bus.req_ready), 32'd0);

    k = 0;
    while (!bus.resp_valid && k < 40) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(n));
    check("product", bus.resp_product, exp_lo);
    check("ovf", 32'(bus.resp_ovf), 32'(exp_ovf));

    for (int h = 0; h < hold; h++) begin
      // a competing request must not be taken while the response is pending
      bus.req_valid = 1'b1;
      bus.req_a     = 32'd9;
      bus.req_b     = 32'd9;
      tick();
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_product", bus.resp_product, exp_lo);
      check("hold_not_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("valid_drop", 32'(bus.resp_valid), 32'd0);
    check("ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    total          = 0;
    passes         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_porta", bus.alu_porta, 32'd0);
    check("rst_portb", bus.alu_portb, 32'd0);
    check("rst_product", bus.resp_product, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));

    run_op(32'd7, 32'd6, 0);
    run_op(32'h1234_5678, 32'd0, 0);
    run_op(32'h8000_0000, 32'd2, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32'd3, 32'd5, 4);
    run_op(32'h0001_0000, 32'h0001_0000, 0);
    run_op(32'h0000_FFFF, 32'h0001_0001, 2);

    for (int r = 0; r < 16; r++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    // Reset mid-RUN abandons the operation
    bus.req_valid = 1'b1;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'h0000_FFFF;
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrun_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrun_porta", bus.alu_porta, 32'd0);
    check("midrun_portb", bus.alu_portb, 32'd0);
    check("midrun_ovf", 32'(bus.resp_ovf), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("midrun_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    bus.resp_ready = 1'b0;

    run_op(32'd11, 32'd13, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_mult.md
Name: alu_seq_mult

Overview:
- Sequential shift-add unsigned multiplier that acts as the requester on the ALU interface.
- Drives the tb-side signals (porta, portb, op) and consumes the ALU result (out), so all accumulation goes through the shared ALU adder.
- Accepts operands over a valid/ready request channel and returns the low 32 bits of the product, plus an overflow flag, over a valid/ready response channel.
- Intended as the multi-cycle MULTU engine beside the execute stage.

Parameters:
EARLY_TERM, 1, 1 = finish once the remaining multiplier bits are all zero; 0 = always run 32 iterations.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
req_valid  input  1  request operands valid.
req_ready  output  1  block can accept a request; high only in IDLE.
req_a  input  32  multiplicand (word_t, unsigned).
req_b  input  32  multiplier (word_t, unsigned).
resp_valid  output  1  product valid; high only in DONE.
resp_ready  input  1  consumer accepts the product.
resp_product  output  32  low 32 bits of req_a*req_b.
resp_ovf  output  1  1 iff the full product is >= 2^32.
alu_porta  output  32  maps to alu_if porta; always equals the acc register.
alu_portb  output  32  maps to alu_if portb; always equals the mcand register.
alu_op  output  aluop_t  maps to alu_if op; constant ALU_ADD.
alu_out  input  32  maps to alu_if out; equals porta + portb mod 2^32.
alu_nf, alu_zf, alu_of  input  1 each  map to alu_if flags; ignored.

Behaviour:
- Registers: state {IDLE, RUN, DONE}, acc[31:0], mcand[31:0], mplier[31:0], iter[5:0], ovf, lost.
- Reset (RST=1 at an edge):
  - state=IDLE; acc, mcand, mplier, iter = 0; ovf, lost = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_product=0, resp_ovf=0, alu_porta=0, alu_portb=0, alu_op=ALU_ADD.
  - Reset mid-RUN or mid-DONE abandons the operation with no response.
- resp_product = acc and resp_ovf = ovf, combinationally from registers, in every state.
- IDLE:
  - On req_valid && req_ready: acc=0, mcand=req_a, mplier=req_b, iter=0, ovf=0, lost=0.
  - If EARLY_TERM=1 and req_b==0, go to DONE; otherwise go to RUN.
- RUN (one iteration per cycle):
  - If mplier[0]==1: acc<=alu_out.
  - In the same case, ovf<=ovf | lost | (alu_out < acc, unsigned carry-out).
  - Every iteration: lost<=lost | mcand[31]; mcand<=mcand<<1; mplier<=mplier>>1; iter<=iter+1.
  - Leave for DONE after this iteration when (EARLY_TERM && (mplier>>1)==0) or iter==31.
  - req_ready=0 throughout; new req_valid is ignored and not consumed.
- DONE:
  - resp_valid=1.
  - Product and flag stay stable until resp_valid && resp_ready; then go to IDLE.
  - req_ready rises on the following cycle; no same-cycle bypass.
  - A response already held (resp_ready low) waits indefinitely.
- Latency, with the request accepted at edge E0:
  - EARLY_TERM=1, b!=0: n = msb_index(b)+1 RUN cycles; resp_valid is high after edge E0+n.
  - EARLY_TERM=1, b==0: resp_valid is high after edge E0.
  - EARLY_TERM=0: always 32 RUN cycles.
  - Maximum latency is 32 cycles to resp_valid.
- Overflow rule: ovf is set iff a partial sum carries out, or a partial product with a previously shifted-out 1 is added. This equals the 64-bit product's upper half being nonzero.
- Back-to-back operation: a new request is accepted at most every n+2 cycles.

Test Plan:
- Reset held 2 cycles, then released: req_ready=1, resp_valid=0, alu_porta=alu_portb=0, alu_op=ALU_ADD.
- a=7, b=6, resp_ready=1: resp_valid high 3 cycles after accept; product=42, ovf=0; idle again the next cycle.
- a=0x12345678, b=0 (EARLY_TERM=1): resp_valid the cycle after accept; product=0, ovf=0.
- a=0x80000000, b=2: product=0, ovf=1.
- a=0xFFFFFFFF, b=0xFFFFFFFF: 32 RUN cycles; product=0x00000001, ovf=1.
- a=3, b=5 with resp_ready held low 4 cycles:
  - resp_valid and product=15 stay stable; a second req_valid is not accepted until 1 cycle after the response handshake.
  - Repeat, asserting RST mid-RUN: the block returns to reset values and no response appears.
